exception_arbiter: RTL and testbench
====================================

# exception_arbiter

Initiator side of the exception interface, sitting at the memory/commit boundary. Collects per-instruction exception flags from the memory stage, synchronizes external interrupt lines, and resolves interrupt pending against the CP0 status and cause fields. Picks the single highest-priority event and issues a one-cycle exception or ERET record toward CP0 and the pc-select logic. A drain window then suppresses wrong-path detections.

## Interface
- DRAIN_CYCLES, 2: cycles after an issued event during which new detections are ignored. Legal values 1..7.
- RESET_LOCATION, 32'hBFC00380: value driven on exc_location for every exception.
- clk  in  1  core clock.
- resetn  in  1  asynchronous, active-low reset.
- m_valid  in  1  memory stage holds a real instruction.
- m_stall  in  1  memory stage is stalled this cycle.
- m_pc  in  32  pc of the memory-stage instruction.
- m_in_delay_slot  in  1  instruction is in a branch delay slot.
- m_exc_flags  in  7  {if_adel, ri, ov, sys, bp, mem_adel, mem_ades}, bit 6 to bit 0.
- m_mem_addr  in  32  data address for load/store.
- m_is_eret  in  1  instruction is ERET.
- ext_int  in  6  raw external interrupt lines.
- cp0_status  in  32  status register: IE at bit 0, EXL at bit 1, IM at bits 15:8.
- cp0_cause  in  32  cause register: IP[1:0] at bits 9:8.
- timer_interrupt  in  1  timer interrupt from CP0.
- exc_valid  out  1  exception record valid; one-cycle pulse.
- exc_code  out  5  ExcCode.
- exc_pc  out  32  faulting pc.
- exc_in_delay_slot  out  1  faulting instruction was in a delay slot.
- exc_badvaddr  out  32  bad virtual address.
- exc_location  out  32  handler vector.
- is_eret  out  1  ERET commit; one-cycle pulse.
- flush  out  1  pipeline flush; high whenever exc_valid or is_eret is high.
- hw_int  out  6  synchronized ext_int, for CP0 cause IP[7:2].

## Operation
- **Interrupt detection:**
  - ip = {timer_interrupt | hw_int[5], hw_int[4:0], cause IP[1:0]}.
  - int_req = IE & ~EXL & |(IM & ip).
- **Detection:** occurs when m_valid is high, the FSM is in IDLE, and (int_req | |m_exc_flags | m_is_eret).
- **Priority, highest first, with exc_code:**
  - interrupt: 0
  - if_adel: 4, badvaddr = m_pc
  - ri: 10
  - ov: 12
  - sys: 8
  - bp: 9
  - mem_adel: 4, badvaddr = m_mem_addr
  - mem_ades: 5, badvaddr = m_mem_addr
  - ERET: lowest priority; is_eret is never asserted together with exc_valid.
- **Record contents:** exc_badvaddr is 0 when the code is not AdEL/AdES. exc_pc = m_pc and exc_in_delay_slot = m_in_delay_slot, both captured at detection.
- **FSM: IDLE, HOLD, ISSUE, DRAIN.**
  - IDLE: on detection, latch the record. Go to HOLD if m_stall is high, else go to ISSUE.
  - HOLD: latched record is frozen. Inputs, including interrupt changes, are ignored. Go to ISSUE in the first cycle m_stall is low.
  - ISSUE: drive exc_valid or is_eret, plus flush, for exactly one cycle. Load the drain counter with DRAIN_CYCLES and go to DRAIN.
  - DRAIN: decrement the counter each cycle; no detection. Go to IDLE after the cycle in which the counter reaches 1.
- **Signal persistence:** m_exc_flags dropping while in HOLD does not cancel the latched event.
- **Reset:** resetn low in any state forces IDLE, clears the latched record, and forces all outputs to 0 asynchronously.
  - exc_location resets to 0 and equals RESET_LOCATION from the first cycle after reset.

## Timing
- Detection in cycle N with m_stall low: exc_valid/is_eret/flush high in cycle N+1 only.
- Detection in cycle N with m_stall high through cycle N+k, low in N+k+1: pulse in cycle N+k+2.
- The earliest next detection is in cycle (issue + DRAIN_CYCLES + 1).
- All exc_* outputs are registered and stable only while exc_valid is high.
- hw_int latency from ext_int is 2 cycles.

## Configuration
- `EXC_INT_SYNC_EN`
  - Defined: ext_int passes through a 2-flop synchronizer, giving 2-cycle latency; the flops reset to 0.
  - Undefined: hw_int = ext_int combinationally, 0-cycle latency.
  - All other behaviour is identical in both cases.

## Structure
- **Shared package `exception_pkg`:**
  - ExcCode constants: CODE_INT, CODE_ADEL, CODE_ADES, CODE_SYS, CODE_BP, CODE_RI, CODE_OV.
  - Flag-bit index localparams.
  - Enum type `exc_state_t` holding the four FSM states.
  - Packed struct `exc_record_t` with fields code, pc, in_delay_slot, badvaddr, is_eret.
- **Sub-module `exc_priority_enc`:** combinational; takes the flags and int_req and produces exc_record_t.
- The FSM and the synchronizer stay in the top module.

## Test plan
- m_valid=1, ri=1, m_pc=32'h8000_0010, m_stall=0 in cycle 5 -> exc_valid=1, flush=1, exc_code=10, exc_pc=32'h8000_0010, exc_badvaddr=0 in cycle 6 only.
- if_adel=1 and mem_ades=1 together, m_pc=32'h8000_0003 -> exc_code=4, exc_badvaddr=32'h8000_0003.
- mem_adel=1, m_mem_addr=32'h1000_0001, m_stall=1 for 3 cycles with the flags dropping after the first cycle -> a single pulse 2 cycles after the stall ends, code=4, badvaddr=32'h1000_0001.
- IE=1, EXL=0, IM=8'h80, timer_interrupt=1, plus ov=1 and m_is_eret=0 -> exc_code=0. Repeat with EXL=1 -> exc_code=12.
- m_is_eret=1, no flags -> is_eret=1, exc_valid=0. A second ov=1 detection in each of the next DRAIN_CYCLES cycles is ignored; the one in the following cycle is issued.
- resetn low in the middle of HOLD -> all outputs 0 immediately. After release, no pulse appears from the discarded record.

Source files
------------

// File: rtl/exception_pkg.sv
// Shared types and constants for the exception arbiter: ExcCodes, flag bit
// positions, FSM states and the latched exception record.
package exception_pkg;

  localparam logic [4:0] CODE_INT  = 5'd0;
  localparam logic [4:0] CODE_ADEL = 5'd4;
  localparam logic [4:0] CODE_ADES = 5'd5;
  localparam logic [4:0] CODE_SYS  = 5'd8;
  localparam logic [4:0] CODE_BP   = 5'd9;
  localparam logic [4:0] CODE_RI   = 5'd10;
  localparam logic [4:0] CODE_OV   = 5'd12;

  // Bit positions inside m_exc_flags, highest priority at the top.
  localparam int FLAG_IF_ADEL  = 6;
  localparam int FLAG_RI       = 5;
  localparam int FLAG_OV       = 4;
  localparam int FLAG_SYS      = 3;
  localparam int FLAG_BP       = 2;
  localparam int FLAG_MEM_ADEL = 1;
  localparam int FLAG_MEM_ADES = 0;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_ISSUE = 2'd2,
    S_DRAIN = 2'd3
  } exc_state_t;

  typedef struct packed {
    logic [4:0]  code;
    logic [31:0] pc;
    logic        in_delay_slot;
    logic [31:0] badvaddr;
    logic        is_eret;
  } exc_record_t;

endpackage

// File: rtl/exc_priority_enc.sv
// Combinational priority encoder: collapses the interrupt request, the
// per-instruction exception flags and ERET into a single exception record.
module exc_priority_enc
  import exception_pkg::*;
(
  input  logic [6:0]  flags,
  input  logic        int_req,
  input  logic [31:0] pc,
  input  logic        in_delay_slot,
  input  logic [31:0] mem_addr,
  input  logic        eret,
  output exc_record_t rec
);

  // Interrupts outrank every synchronous exception; ERET only wins when
  // nothing else is pending, so it never coexists with an exception record.
  always_comb begin
    rec               = '0;
    rec.pc            = pc;
    rec.in_delay_slot = in_delay_slot;
    if (int_req) begin
      rec.code = CODE_INT;
    end else if (flags[FLAG_IF_ADEL]) begin
      rec.code     = CODE_ADEL;
      rec.badvaddr = pc;
    end else if (flags[FLAG_RI]) begin
      rec.code = CODE_RI;
    end else if (flags[FLAG_OV]) begin
      rec.code = CODE_OV;
    end else if (flags[FLAG_SYS]) begin
      rec.code = CODE_SYS;
    end else if (flags[FLAG_BP]) begin
      rec.code = CODE_BP;
    end else if (flags[FLAG_MEM_ADEL]) begin
      rec.code     = CODE_ADEL;
      rec.badvaddr = mem_addr;
    end else if (flags[FLAG_MEM_ADES]) begin
      rec.code     = CODE_ADES;
      rec.badvaddr = mem_addr;
    end else if (eret) begin
      rec.is_eret = 1'b1;
    end
  end

endmodule

// File: rtl/exception_arbiter.sv
// Exception initiator at the memory/commit boundary: detects, holds through
// stalls, issues a one-cycle record, then drains. EXC_INT_SYNC_EN adds a
// 2-flop synchronizer on ext_int.
module exception_arbiter
  import exception_pkg::*;
#(
  parameter int          DRAIN_CYCLES   = 2,
  parameter logic [31:0] RESET_LOCATION = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m_valid,
  input  logic        m_stall,
  input  logic [31:0] m_pc,
  input  logic        m_in_delay_slot,
  input  logic [6:0]  m_exc_flags,
  input  logic [31:0] m_mem_addr,
  input  logic        m_is_eret,
  input  logic [5:0]  ext_int,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic        timer_interrupt,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_pc,
  output logic        exc_in_delay_slot,
  output logic [31:0] exc_badvaddr,
  output logic [31:0] exc_location,
  output logic        is_eret,
  output logic        flush,
  output logic [5:0]  hw_int
);

  exc_state_t  state;
  exc_record_t rec_q;
  exc_record_t enc_rec;
  exc_record_t issue_rec;
  logic [2:0]  drain_cnt;
  logic [7:0]  ip;
  logic        int_req;
  logic        detect;
  logic        fire;
  logic        unused_cp0_bits;

`ifdef EXC_INT_SYNC_EN
  logic [5:0] int_meta;
  logic [5:0] int_sync;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      int_meta <= '0;
      int_sync <= '0;
    end else begin
      int_meta <= ext_int;
      int_sync <= int_meta;
    end
  end

  assign hw_int = int_sync;
`else
  assign hw_int = ext_int;
`endif

  assign unused_cp0_bits = ^{cp0_status[31:16], cp0_status[7:2],
                             cp0_cause[31:10], cp0_cause[7:0]};

  exc_priority_enc u_prio (
    .flags         (m_exc_flags),
    .int_req       (int_req),
    .pc            (m_pc),
    .in_delay_slot (m_in_delay_slot),
    .mem_addr      (m_mem_addr),
    .eret          (m_is_eret),
    .rec           (enc_rec)
  );

  // A held record is released from HOLD; a fresh one bypasses straight to issue.
  always_comb begin
    ip        = {timer_interrupt | hw_int[5], hw_int[4:0], cp0_cause[9:8]};
    int_req   = cp0_status[STATUS_IE] & ~cp0_status[STATUS_EXL]
                & (|(cp0_status[15:8] & ip));
    detect    = (state == S_IDLE) & m_valid
                & (int_req | (|m_exc_flags) | m_is_eret);
    fire      = ~m_stall & (detect | (state == S_HOLD));
    issue_rec = (state == S_HOLD) ? rec_q : enc_rec;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state             <= S_IDLE;
      rec_q             <= '0;
      drain_cnt         <= '0;
      exc_valid         <= 1'b0;
      exc_code          <= '0;
      exc_pc            <= '0;
      exc_in_delay_slot <= 1'b0;
      exc_badvaddr      <= '0;
      exc_location      <= '0;
      is_eret           <= 1'b0;
      flush             <= 1'b0;
    end else begin
      exc_location      <= RESET_LOCATION;
      exc_valid         <= 1'b0;
      is_eret           <= 1'b0;
      flush             <= 1'b0;
      exc_code          <= '0;
      exc_pc            <= '0;
      exc_in_delay_slot <= 1'b0;
      exc_badvaddr      <= '0;

      if (fire) begin
        exc_valid         <= ~issue_rec.is_eret;
        is_eret           <= issue_rec.is_eret;
        flush             <= 1'b1;
        exc_code          <= issue_rec.code;
        exc_pc            <= issue_rec.pc;
        exc_in_delay_slot <= issue_rec.in_delay_slot;
        exc_badvaddr      <= issue_rec.badvaddr;
      end

      case (state)
        S_IDLE: begin
          if (detect) begin
            rec_q <= enc_rec;
            state <= m_stall ? S_HOLD : S_ISSUE;
          end
        end
        S_HOLD: begin
          if (!m_stall) state <= S_ISSUE;
        end
        S_ISSUE: begin
          drain_cnt <= 3'(DRAIN_CYCLES);
          state     <= S_DRAIN;
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt - 3'd1;
          if (drain_cnt == 3'd1) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_arbiter.sv
// Randomized and directed bench for exception_arbiter, checked against a
// cycle-counting reference model of the issue/drain rules.
module tb_exception_arbiter;

  localparam int          D   = 2;
  localparam logic [31:0] LOC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m_valid, m_stall, m_in_delay_slot, m_is_eret, timer_interrupt;
  logic [31:0] m_pc, m_mem_addr, cp0_status, cp0_cause;
  logic [6:0]  m_exc_flags;
  logic [5:0]  ext_int;
  logic        exc_valid, exc_in_delay_slot, is_eret, flush;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, exc_badvaddr, exc_location;
  logic [5:0]  hw_int;

  int checks = 0;
  int errors = 0;

  // Reference model state: cycle count, earliest allowed detection cycle,
  // a held event and the ext_int history.
  int          cyc;
  int          next_free;
  bit          pend;
  logic [4:0]  pend_code;
  logic [31:0] pend_pc, pend_badv;
  bit          pend_ds, pend_eret;
  logic [5:0]  ext_d1, ext_d2;
  bit          exp_exc, exp_eret, exp_ds;
  logic [4:0]  exp_code;
  logic [31:0] exp_pc, exp_badv;

  exception_arbiter #(.DRAIN_CYCLES(D), .RESET_LOCATION(LOC)) dut (
    .clk(clk), .resetn(resetn), .m_valid(m_valid), .m_stall(m_stall),
    .m_pc(m_pc), .m_in_delay_slot(m_in_delay_slot), .m_exc_flags(m_exc_flags),
    .m_mem_addr(m_mem_addr), .m_is_eret(m_is_eret), .ext_int(ext_int),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause),
    .timer_interrupt(timer_interrupt), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_pc(exc_pc), .exc_in_delay_slot(exc_in_delay_slot),
    .exc_badvaddr(exc_badvaddr), .exc_location(exc_location),
    .is_eret(is_eret), .flush(flush), .hw_int(hw_int)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void classify(input logic [6:0] f, input bit irq,
                                   input logic [31:0] pc, input logic [31:0] addr,
                                   output logic [4:0] code, output logic [31:0] badv,
                                   output bit eret);
    int codes [7] = '{5, 4, 9, 8, 12, 10, 4};
    code = 5'd0;
    badv = 32'd0;
    eret = 1'b0;
    if (irq) return;
    for (int b = 6; b >= 0; b--) begin
      if (f[b]) begin
        code = 5'(codes[b]);
        if (code == 5'd4 || code == 5'd5) badv = (b == 6) ? pc : addr;
        return;
      end
    end
    eret = 1'b1;
  endfunction

  task automatic model_reset();
    pend      = 1'b0;
    next_free = 0;
    ext_d1    = '0;
    ext_d2    = '0;
    exp_exc   = 1'b0;
    exp_eret  = 1'b0;
  endtask

  task automatic idle_inputs();
    m_valid = 0; m_stall = 0; m_pc = '0; m_in_delay_slot = 0; m_exc_flags = '0;
    m_mem_addr = '0; m_is_eret = 0; ext_int = '0; cp0_status = '0;
    cp0_cause = '0; timer_interrupt = 0;
  endtask

  // Applies the current inputs for one cycle, predicts the next cycle's
  // outputs, then compares them half a cycle after the clock edge.
  task automatic applyStimulus();
    logic [5:0]  hw_now;
    logic [7:0]  ip;
    bit          irq;
    logic [4:0]  code;
    logic [31:0] badv;
    bit          er;
    #1;
`ifdef EXC_INT_SYNC_EN
    hw_now = ext_d2;
`else
    hw_now = ext_int;
`endif
    checkOutput("hw_int", {26'd0, hw_int}, {26'd0, hw_now});
    ip  = {timer_interrupt | hw_now[5], hw_now[4:0], cp0_cause[9:8]};
    irq = cp0_status[0] && !cp0_status[1] && ((cp0_status[15:8] & ip) != 0);
    exp_exc  = 1'b0;
    exp_eret = 1'b0;
    if (pend) begin
      if (!m_stall) begin
        exp_eret = pend_eret; exp_exc = !pend_eret; exp_code = pend_code;
        exp_pc = pend_pc; exp_ds = pend_ds; exp_badv = pend_badv;
        pend = 1'b0;
        next_free = cyc + D + 2;
      end
    end else if (cyc >= next_free && m_valid &&
                 (irq || m_exc_flags != 0 || m_is_eret)) begin
      classify(m_exc_flags, irq, m_pc, m_mem_addr, code, badv, er);
      if (!m_stall) begin
        exp_eret = er; exp_exc = !er; exp_code = code;
        exp_pc = m_pc; exp_ds = m_in_delay_slot; exp_badv = badv;
        next_free = cyc + D + 2;
      end else begin
        pend = 1'b1; pend_eret = er; pend_code = code;
        pend_pc = m_pc; pend_ds = m_in_delay_slot; pend_badv = badv;
      end
    end
    ext_d2 = ext_d1;
    ext_d1 = ext_int;
    cyc++;
    @(posedge clk);
    @(negedge clk);
    checkOutput("exc_valid", {31'd0, exc_valid}, {31'd0, exp_exc});
    checkOutput("is_eret", {31'd0, is_eret}, {31'd0, exp_eret});
    checkOutput("flush", {31'd0, flush}, {31'd0, exp_exc | exp_eret});
    checkOutput("exc_location", exc_location, LOC);
    if (exp_exc) begin
      checkOutput("exc_code", {27'd0, exc_code}, {27'd0, exp_code});
      checkOutput("exc_pc", exc_pc, exp_pc);
      checkOutput("exc_ds", {31'd0, exc_in_delay_slot}, {31'd0, exp_ds});
      checkOutput("exc_badvaddr", exc_badvaddr, exp_badv);
    end
  endtask

  task automatic idle_cycles(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    cyc = 0;
    resetn = 1'b0;
    idle_inputs();
    model_reset();
    #3;
    checkOutput("rst_exc_valid", {31'd0, exc_valid}, 32'd0);
    checkOutput("rst_flush", {31'd0, flush}, 32'd0);
    checkOutput("rst_location", exc_location, 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    idle_cycles(3);

    // ri, no stall
    m_valid = 1; m_exc_flags = 7'b0100000; m_pc = 32'h8000_0010;
    applyStimulus();
    idle_cycles(4);

    // if_adel together with mem_ades
    m_valid = 1; m_exc_flags = 7'b1000001; m_pc = 32'h8000_0003;
    m_mem_addr = 32'h2000_0000; m_in_delay_slot = 1;
    applyStimulus();
    idle_cycles(4);

    // mem_adel held through a 3-cycle stall while the flag drops
    m_valid = 1; m_exc_flags = 7'b0000010; m_mem_addr = 32'h1000_0001;
    m_pc = 32'h8000_0040; m_stall = 1;
    applyStimulus();
    m_exc_flags = '0; m_mem_addr = '0;
    applyStimulus();
    applyStimulus();
    m_stall = 0; m_valid = 0;
    applyStimulus();
    idle_cycles(5);

    // timer interrupt over ov, then again with EXL set
    for (int k = 0; k < 2; k++) begin
      m_valid = 1; m_exc_flags = 7'b0010000; timer_interrupt = 1;
      cp0_status = (k == 0) ? 32'h0000_8001 : 32'h0000_8003;
      m_pc = 32'h8000_0100;
      applyStimulus();
      idle_cycles(4);
    end

    // ERET followed by ov detections through the drain window
    m_valid = 1; m_is_eret = 1; m_pc = 32'h8000_0200;
    applyStimulus();
    m_is_eret = 0; m_exc_flags = 7'b0010000;
    for (int i = 0; i < D + 1; i++) applyStimulus();
    idle_cycles(4);

    // reset asserted in the middle of HOLD
    m_valid = 1; m_exc_flags = 7'b0010000; m_stall = 1; m_pc = 32'h8000_0300;
    applyStimulus();
    m_exc_flags = '0;
    applyStimulus();
    #2 resetn = 1'b0;
    #1;
    checkOutput("hold_rst_valid", {31'd0, exc_valid}, 32'd0);
    checkOutput("hold_rst_flush", {31'd0, flush}, 32'd0);
    checkOutput("hold_rst_location", exc_location, 32'd0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    resetn = 1'b1;
    idle_cycles(6);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      m_valid         = ($urandom_range(0, 9) < 7);
      m_stall         = ($urandom_range(0, 9) < 3);
      m_pc            = $urandom();
      m_mem_addr      = $urandom();
      m_in_delay_slot = 1'($urandom_range(0, 1));
      for (int b = 0; b < 7; b++) m_exc_flags[b] = ($urandom_range(0, 11) == 0);
      m_is_eret       = ($urandom_range(0, 7) == 0);
      for (int b = 0; b < 6; b++) ext_int[b] = ($urandom_range(0, 7) == 0);
      timer_interrupt = ($urandom_range(0, 9) == 0);
      cp0_status      = {16'd0, 8'($urandom()), 6'd0,
                         1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1))};
      cp0_cause       = {22'd0, 2'($urandom()), 8'd0};
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
